// File: rtl/wb_multi_slave.sv
// Wishbone slave fanning out to a memory controller and N peripheral
// channels, with per-target ready, timeout and decode-miss errors.
module wb_multi_slave #(
   parameter int               ADR_W        = 26,
   parameter int               DAT_W        = 32,
   parameter int               N_CH         = 4,
   parameter int               CH_SPAN_LOG2 = 4,
   parameter logic [ADR_W-1:0] PER_BASE     = 26'h0010000,
   parameter int               TIMEOUT      = 15,
   localparam int              CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cyc_i,
   input  logic                  stb_i,
   input  logic                  we_i,
   input  logic [ADR_W-1:0]      adr_i,
   input  logic [DAT_W-1:0]      dat_i,
   output logic [DAT_W-1:0]      dat_o,
   output logic                  ack_o,
   output logic                  err_o,
   output logic [CH_W:0]         tag_o,
   output logic [ADR_W-1:0]      mem_adr_o,
   output logic [DAT_W-1:0]      mem_dat_o,
   output logic                  mem_r_o,
   output logic                  mem_w_o,
   input  logic [DAT_W-1:0]      mem_dat_i,
   input  logic                  mem_rdy_i,
   output logic [N_CH-1:0]       per_sel_o,
   output logic                  per_w_o,
   output logic [CH_SPAN_LOG2-1:0] per_adr_o,
   output logic [DAT_W-1:0]      per_dat_o,
   input  logic [N_CH*DAT_W-1:0] per_dat_i,
   input  logic [N_CH-1:0]       per_rdy_i
);

   localparam int HI = CH_SPAN_LOG2 + CH_W;
   localparam int NP = 1 << CH_W;
   localparam logic [CH_W:0] N_CH_L = (CH_W+1)'(N_CH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MEM,
      S_PER,
      S_RESP,
      S_ERR
   } state_t;

   state_t state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [CH_W:0]     tgt_q, tgt_d;
   logic [ADR_W-1:0]  adr_q, adr_d;
   logic [DAT_W-1:0]  dat_q, dat_d;
   logic              mem_r_q, mem_r_d;
   logic              mem_w_q, mem_w_d;
   logic [N_CH-1:0]   sel_q, sel_d;
   logic              per_w_q, per_w_d;
   logic [DAT_W-1:0]  rdat_q, rdat_d;
   logic [CH_W:0]     tag_q, tag_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;

   logic              win_hit;
   logic [CH_W-1:0]   ch_dec;
   logic              ch_ok;
   logic [NP-1:0]     rdy_pad;
   logic [DAT_W-1:0]  pdat [NP];
   logic              tgt_rdy;
   logic [DAT_W-1:0]  tgt_dat;

   assign win_hit = adr_i[ADR_W-1:HI] == PER_BASE[ADR_W-1:HI];
   assign ch_dec  = adr_i[CH_SPAN_LOG2 +: CH_W];
   assign ch_ok   = {1'b0, ch_dec} < N_CH_L;
   assign rdy_pad = NP'(per_rdy_i);

   // Unpack channel read data; unused slots of the power-of-two table read 0.
   always_comb begin
      for (int c = 0; c < NP; c++) pdat[c] = '0;
      for (int c = 0; c < N_CH; c++) pdat[c] = per_dat_i[c*DAT_W +: DAT_W];
   end

   assign tgt_rdy = (state_q == S_MEM) ? mem_rdy_i : rdy_pad[ch_q];
   assign tgt_dat = (state_q == S_MEM) ? mem_dat_i : pdat[ch_q];

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      ch_d    = ch_q;
      tgt_d   = tgt_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      mem_r_d = mem_r_q;
      mem_w_d = mem_w_q;
      sel_d   = sel_q;
      per_w_d = per_w_q;
      rdat_d  = rdat_q;
      tag_d   = tag_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cyc_i && stb_i) begin
               adr_d = adr_i;
               dat_d = dat_i;
               we_d  = we_i;
               ch_d  = ch_dec;
               cnt_d = '0;
               tgt_d = win_hit ? {1'b1, ch_dec} : '0;
               if (win_hit && ch_ok) begin
                  sel_d   = N_CH'(1) << ch_dec;
                  per_w_d = we_i;
                  state_d = S_PER;
               end else if (win_hit) begin
                  state_d = S_ERR;
               end else begin
                  mem_w_d = we_i;
                  mem_r_d = ~we_i;
                  state_d = S_MEM;
               end
            end
         end
         S_MEM, S_PER: begin
            if (!cyc_i) begin
               mem_r_d = 1'b0;
               mem_w_d = 1'b0;
               sel_d   = '0;
               per_w_d = 1'b0;
               state_d = S_IDLE;
            end else if (tgt_rdy) begin
               mem_r_d = 1'b0;
               mem_w_d = 1'b0;
               sel_d   = '0;
               per_w_d = 1'b0;
               ack_d   = 1'b1;
               rdat_d  = we_q ? '0 : tgt_dat;
               tag_d   = tgt_q;
               state_d = S_RESP;
            end else if (cnt_q == 8'(TIMEOUT)) begin
               mem_r_d = 1'b0;
               mem_w_d = 1'b0;
               sel_d   = '0;
               per_w_d = 1'b0;
               err_d   = 1'b1;
               rdat_d  = '0;
               tag_d   = tgt_q;
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         S_ERR: begin
            // Timeout raises err on entry; a decode miss raises it here.
            if (!err_q) begin
               err_d  = 1'b1;
               rdat_d = '0;
               tag_d  = tgt_q;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         ch_q    <= '0;
         tgt_q   <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
         mem_r_q <= 1'b0;
         mem_w_q <= 1'b0;
         sel_q   <= '0;
         per_w_q <= 1'b0;
         rdat_q  <= '0;
         tag_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         ch_q    <= ch_d;
         tgt_q   <= tgt_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         mem_r_q <= mem_r_d;
         mem_w_q <= mem_w_d;
         sel_q   <= sel_d;
         per_w_q <= per_w_d;
         rdat_q  <= rdat_d;
         tag_q   <= tag_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign dat_o     = rdat_q;
   assign ack_o     = ack_q;
   assign err_o     = err_q;
   assign tag_o     = tag_q;
   assign mem_adr_o = adr_q;
   assign mem_dat_o = dat_q;
   assign mem_r_o   = mem_r_q;
   assign mem_w_o   = mem_w_q;
   assign per_sel_o = sel_q;
   assign per_w_o   = per_w_q;
   assign per_adr_o = adr_q[CH_SPAN_LOG2-1:0];
   assign per_dat_o = dat_q;

endmodule
